// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch stage with a one-entry instruction buffer feeding IF/ID.
// It issues one instruction memory request at a time and handles the branch
// delay slot, flush redirects and misaligned fetch addresses.
//
// Ports
//   clk, rset          clock, asynchronous active-low reset
//   hold               1 = IF/ID must not load this cycle
//   flush, flush_pc    single-cycle redirect request and its target
//   br_valid/taken/target  branch resolved in ID (delay slot follows)
//   inst_req/inst_addr      memory request (one cycle per fetch)
//   inst_rdata/inst_data_ok memory read data and its strobe
//   if_id_load         IF/ID load enable
//   instruction_out, PC_out, illegal_pc_out, in_delayslot_out
//                      registered instruction buffer contents
// ----------------------------------------------------------------------------
module if_fetch_stage (
    input  logic        clk,
    input  logic        rset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        if_id_load,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out,
    output logic        illegal_pc_out,
    output logic        in_delayslot_out
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DISCARD
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic        r_ds_pend;
    logic        r_br_taken;
    logic [31:0] r_br_target;

    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_illegal;
    logic        r_in_ds;

    logic [31:0] w_next_pc;
    logic        w_pc_aligned;
    logic        w_next_aligned;
    logic        w_deliver;
    logic        w_load_fetch;
    logic        w_load_illegal;
    logic        w_load_bubble;
    logic        w_ds_mark;

    // r_pc always equals the PC of the buffered instruction while FULL, so the
    // successor is computed from r_pc and the buffered delay-slot flag.
    assign w_next_pc      = (r_in_ds && r_br_taken) ? r_br_target : r_pc + 32'd4;
    assign w_pc_aligned   = (r_pc[1:0] == 2'b00);
    assign w_next_aligned = (w_next_pc[1:0] == 2'b00);

    assign w_deliver      = (r_state == S_FULL) && !hold && !flush;
    assign w_load_fetch   = (r_state == S_WAIT) && inst_data_ok && !flush;
    assign w_load_illegal = (r_state == S_REQ) && !w_pc_aligned && !flush;
    assign w_load_bubble  = flush && (r_state != S_DISCARD);
    // A load in the same cycle as br_valid already counts as the delay slot.
    assign w_ds_mark      = r_ds_pend || br_valid;

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (flush)             w_next_state = S_REQ;
                else if (w_pc_aligned) w_next_state = S_WAIT;
                else                   w_next_state = S_FULL;
            end
            S_WAIT: begin
                if (flush)             w_next_state = inst_data_ok ? S_REQ : S_DISCARD;
                else if (inst_data_ok) w_next_state = S_FULL;
            end
            S_FULL: begin
                if (flush)             w_next_state = S_REQ;
                else if (!hold)        w_next_state = w_next_aligned ? S_WAIT : S_REQ;
            end
            S_DISCARD: begin
                if (inst_data_ok)      w_next_state = S_REQ;
            end
            default:                   w_next_state = S_REQ;
        endcase
    end

    always_comb begin
        inst_req   = 1'b0;
        inst_addr  = r_pc;
        if_id_load = 1'b0;
        case (r_state)
            S_REQ:  inst_req = w_pc_aligned && !flush;
            S_FULL: begin
                inst_addr  = w_next_pc;
                inst_req   = !hold && !flush && w_next_aligned;
                if_id_load = !hold;
            end
            default: ;
        endcase
        if (w_load_bubble) if_id_load = 1'b1;
        // Reset is asynchronous, so the combinational strobes are gated too.
        if (!rset) begin
            inst_req   = 1'b0;
            if_id_load = 1'b0;
        end
    end

    // ------------------------------------------------------ pc / branch state
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_pc        <= RESET_PC;
            r_ds_pend   <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else if (flush) begin
            r_pc <= flush_pc;
            // A repeated flush while dropping a stale response only retargets.
            if (r_state != S_DISCARD) begin
                r_ds_pend   <= 1'b0;
                r_br_taken  <= 1'b0;
                r_br_target <= '0;
            end
        end else begin
            if (w_deliver) r_pc <= w_next_pc;

            if (w_load_fetch || w_load_illegal) r_ds_pend <= 1'b0;
            else if (br_valid)                  r_ds_pend <= 1'b1;

            if (br_valid && !r_ds_pend) begin
                r_br_taken  <= br_taken;
                r_br_target <= br_target;
            end else if (w_deliver && r_in_ds) begin
                r_br_taken  <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------- instruction buffer
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_illegal <= 1'b0;
            r_in_ds   <= 1'b0;
        end else if (w_load_bubble) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_illegal <= 1'b0;
            r_in_ds   <= 1'b0;
        end else if (w_load_fetch) begin
            r_inst    <= inst_rdata;
            r_inst_pc <= r_pc;
            r_illegal <= 1'b0;
            r_in_ds   <= w_ds_mark;
        end else if (w_load_illegal) begin
            r_inst    <= '0;
            r_inst_pc <= r_pc;
            r_illegal <= 1'b1;
            r_in_ds   <= w_ds_mark;
        end
    end

    assign instruction_out  = r_inst;
    assign PC_out           = r_inst_pc;
    assign illegal_pc_out   = r_illegal;
    assign in_delayslot_out = r_in_ds;

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001: clk  in  1  single system clock; all state updates on posedge clk.
REQ-002: rset  in  1  reset, asynchronous, active-low.
REQ-003: hold  in  1  downstream hold from the hazard unit; 1 = the IF/ID register must not load.
REQ-004: flush  in  1  exception/ERET redirect request, single-cycle pulse.
REQ-005: flush_pc  in  32  redirect target, valid while flush=1.
REQ-006: br_valid  in  1  single-cycle pulse: the instruction now in ID is a branch or jump.
REQ-007: br_taken  in  1  qualifies br_valid; 1 = redirect to br_target after the delay slot.
REQ-008: br_target  in  32  branch/jump target, valid while br_valid=1.
REQ-009: inst_req  out  1  instruction memory request, one cycle per fetch.
REQ-010: inst_addr  out  32  fetch address, valid while inst_req=1.
REQ-011: inst_rdata  in  32  fetched word, valid while inst_data_ok=1.
REQ-012: inst_data_ok  in  1  read-data strobe, arriving at least 1 cycle after inst_req; at most one request is outstanding.
REQ-013: if_id_load  out  1  IF/ID load enable; 1 = load, 0 = keep.
REQ-014: instruction_out  out  32  instruction presented to IF/ID.
REQ-015: PC_out  out  32  PC of instruction_out.
REQ-016: illegal_pc_out  out  1  1 = PC_out is misaligned (PC_out[1:0] != 0).
REQ-017: in_delayslot_out  out  1  1 = instruction_out occupies a branch delay slot.

Function
REQ-018: FSM states: REQ (issue fetch), WAIT (await data), FULL (buffer holds an instruction), DISCARD (drop one stale response).
REQ-019: REQ with pc[1:0]=0: inst_req=1 and inst_addr=pc for exactly one cycle, then go to WAIT.
REQ-020: REQ with pc[1:0]!=0: inst_req stays 0; the buffer is loaded with instruction 0, PC pc and illegal=1; go to FULL.
REQ-021: WAIT with inst_data_ok=1: the buffer captures inst_rdata, pc and illegal=0; go to FULL.
REQ-022: Buffer behaviour: instruction_out, PC_out, illegal_pc_out and in_delayslot_out are driven from registers only.
REQ-023: Buffer behaviour: those outputs are unchanged except at a buffer load.
REQ-024: FULL with hold=0: if_id_load=1, pc is updated to next_pc, and inst_req=1 / inst_addr=next_pc are issued combinationally in the same cycle; go to WAIT (aligned next_pc) or REQ (misaligned).
REQ-025: FULL with hold=1: if_id_load=0; stay in FULL; no request is issued.
REQ-026: next_pc is br_target when the delivered instruction is a delay slot of a taken branch; otherwise next_pc is pc+4, wrapping modulo 2^32.
REQ-027: Delay-slot marking: a br_valid pulse sets ds_pend.
REQ-028: Delay-slot marking: the first buffer load at or after the br_valid cycle takes in_delayslot=1 and clears ds_pend.
REQ-029: Delay-slot marking: br_taken and br_target are latched with br_valid and used when that delay slot is delivered.
REQ-030: br_valid arriving while ds_pend=1 is ignored.
REQ-031: flush has priority over hold, br_valid and inst_data_ok.
REQ-032: On flush, pc becomes flush_pc, ds_pend and the pending branch are cleared, and if_id_load=1 in that cycle.
REQ-033: On flush, the buffer is reloaded next edge with the bubble: instruction 0, PC 0, illegal 0, delay-slot 0.
REQ-034: flush in WAIT without inst_data_ok goes to DISCARD; the next inst_data_ok is dropped, then go to REQ.
REQ-035: flush in WAIT coincident with inst_data_ok, or flush in REQ or FULL, goes directly to REQ.
REQ-036: In DISCARD, no inst_req is issued and if_id_load=0; a second flush only updates pc.

Reset
REQ-037: While rset=0: pc=32'hBFC00000, state REQ, inst_req=0, if_id_load=0, ds_pend=0.
REQ-038: While rset=0, all buffered outputs are 0.
REQ-039: Reset asserted mid-operation abandons any outstanding request; the first post-reset inst_data_ok not preceded by inst_req is ignored.
REQ-040: The first cycle after rset rises issues inst_req=1 with inst_addr=32'hBFC00000.

Verification
REQ-041: Reset release, 1-cycle memory, hold=0 -> fetches BFC00000, BFC00004, BFC00008, each delivered with if_id_load=1 and correct PC_out, one instruction per 2 cycles.
REQ-042: hold=1 for 5 cycles while FULL -> if_id_load=0, outputs stable, no inst_req; on release one load of the same instruction, then the next fetch.
REQ-043: br_valid=1, br_taken=1, target 0x80001000, while fetching 0xBFC00010 -> 0xBFC00010 delivered with in_delayslot=1; next inst_addr is 0x80001000 with in_delayslot=0.
REQ-044: flush to 0xBFC00380 during WAIT with 4-cycle memory latency -> bubble load (instruction 0), stale data dropped, next inst_addr=0xBFC00380.
REQ-045: br_target 0x80000002 taken -> after the delay slot, no inst_req; delivered with illegal_pc_out=1, PC_out=0x80000002, instruction 0.
REQ-046: rset pulsed low while in WAIT -> all outputs 0 immediately; a late inst_data_ok is ignored; refetch from BFC00000.
